// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and SCLK edge selection.
package spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ARMED  = 2'd1;
  localparam state_t ACTIVE = 2'd2;

  // Leading edge leaves the CPOL level; sampling uses the leading edge when CPHA=0.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_slave_frame_if.sv
// Host-side word interface of the SPI slave (transmit holding register and receive status).
interface spi_slave_frame_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              frame_err;

  modport master (
    output tx_data, tx_load,
    input  tx_ready, rx_data, rx_valid, tx_underrun, frame_err
  );

  modport slave (
    input  tx_data, tx_load,
    output tx_ready, rx_data, rx_valid, tx_underrun, frame_err
  );

endinterface

// File: rtl/spi_input_sync.sv
// Synchronises cs_n/sclk/mosi into the clk domain and flags sclk edges.
module spi_input_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          CPOL        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic sclk,
  input  logic mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sclk_rise_c,
  output logic sclk_fall_c
);

  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_d;

  // cs_n resets to "selected" so a frame already in progress is never joined after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q   <= '0;
      sclk_q <= {SYNC_STAGES{CPOL}};
      mosi_q <= '0;
      sclk_d <= CPOL;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign cs_n_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_q[SYNC_STAGES-1];
  assign sclk_rise_c =  sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall_c = ~sclk_q[SYNC_STAGES-1] &  sclk_d;

endmodule

// File: rtl/spi_slave_frame.sv
// Oversampled full-duplex SPI slave with configurable mode, word width, bit order and multi-word frames.
module spi_slave_frame
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs_n,
  input  logic               sclk,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  spi_slave_frame_if.slave   bus
);

  localparam int unsigned        CNT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]   LAST_BIT    = CNT_W'(DATA_W - 1);
  localparam bit                 SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic cs_n_s, mosi_s, sclk_rise_c, sclk_fall_c;
  logic sample_c, shift_c;

  spi_input_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .CPOL        (CPOL)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .mosi        (mosi),
    .cs_n_s      (cs_n_s),
    .mosi_s      (mosi_s),
    .sclk_rise_c (sclk_rise_c),
    .sclk_fall_c (sclk_fall_c)
  );

  assign sample_c = SAMPLE_RISE ? sclk_rise_c : sclk_fall_c;
  assign shift_c  = SAMPLE_RISE ? sclk_fall_c : sclk_rise_c;

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
  logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
  logic [DATA_W-1:0] hold, hold_nxt;
  logic              hold_empty, hold_empty_nxt;
  logic              load_pend, load_pend_nxt;
  logic              urun_pend, urun_pend_nxt;
  logic              miso_nxt, miso_oe_nxt;
  logic [DATA_W-1:0] rx_data, rx_data_nxt;
  logic              rx_valid, rx_valid_nxt;
  logic              tx_underrun, tx_underrun_nxt;
  logic              frame_err, frame_err_nxt;
  logic              word_load;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] rx_word;

  // Next-state and datapath; boundary-load underruns are reported when the next word's first bit is sampled
  always_comb begin
    state_nxt       = state;
    bit_cnt_nxt     = bit_cnt;
    rx_shift_nxt    = rx_shift;
    tx_shift_nxt    = tx_shift;
    hold_nxt        = hold;
    hold_empty_nxt  = hold_empty;
    load_pend_nxt   = load_pend;
    urun_pend_nxt   = urun_pend;
    miso_nxt        = miso;
    rx_data_nxt     = rx_data;
    rx_valid_nxt    = 1'b0;
    tx_underrun_nxt = 1'b0;
    frame_err_nxt   = 1'b0;
    word_load       = 1'b0;
    load_word       = hold_empty ? '0 : hold;
    rx_word         = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};

    case (state)
      IDLE: begin
        if (cs_n_s) state_nxt = ARMED;
      end
      ARMED: begin
        if (!cs_n_s) begin
          state_nxt       = ACTIVE;
          bit_cnt_nxt     = '0;
          load_pend_nxt   = 1'b0;
          urun_pend_nxt   = 1'b0;
          word_load       = 1'b1;
          tx_underrun_nxt = hold_empty;
          if (CPHA) begin
            tx_shift_nxt = load_word;
          end else begin
            miso_nxt     = head_bit(load_word);
            tx_shift_nxt = advance(load_word);
          end
        end
      end
      ACTIVE: begin
        if (cs_n_s) begin
          state_nxt     = ARMED;
          frame_err_nxt = (bit_cnt != '0);
          bit_cnt_nxt   = '0;
          load_pend_nxt = 1'b0;
          urun_pend_nxt = 1'b0;
        end else begin
          if (sample_c) begin
            rx_shift_nxt = rx_word;
            if (urun_pend) begin
              tx_underrun_nxt = 1'b1;
              urun_pend_nxt   = 1'b0;
            end
            if (bit_cnt == LAST_BIT) begin
              rx_data_nxt   = rx_word;
              rx_valid_nxt  = 1'b1;
              bit_cnt_nxt   = '0;
              load_pend_nxt = 1'b1;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end
          if (shift_c) begin
            if (load_pend) begin
              word_load     = 1'b1;
              load_pend_nxt = 1'b0;
              urun_pend_nxt = hold_empty;
              miso_nxt      = head_bit(load_word);
              tx_shift_nxt  = advance(load_word);
            end else begin
              miso_nxt      = head_bit(tx_shift);
              tx_shift_nxt  = advance(tx_shift);
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A host write in the same cycle as an empty-register load is kept for the following word
    if (word_load) hold_empty_nxt = 1'b1;
    if (bus.tx_load && hold_empty) begin
      hold_nxt       = bus.tx_data;
      hold_empty_nxt = 1'b0;
    end

    miso_oe_nxt = (state_nxt == ACTIVE);
    if (!miso_oe_nxt) miso_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold        <= '0;
      hold_empty  <= 1'b1;
      load_pend   <= 1'b0;
      urun_pend   <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      rx_shift    <= rx_shift_nxt;
      tx_shift    <= tx_shift_nxt;
      hold        <= hold_nxt;
      hold_empty  <= hold_empty_nxt;
      load_pend   <= load_pend_nxt;
      urun_pend   <= urun_pend_nxt;
      miso        <= miso_nxt;
      miso_oe     <= miso_oe_nxt;
      rx_data     <= rx_data_nxt;
      rx_valid    <= rx_valid_nxt;
      tx_underrun <= tx_underrun_nxt;
      frame_err   <= frame_err_nxt;
    end
  end

  assign bus.tx_ready    = hold_empty;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.tx_underrun = tx_underrun;
  assign bus.frame_err   = frame_err;

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame: five instances covering SPI modes 0-3 and LSB-first order.
module tb_spi_slave_frame;

  localparam int          NDUT  = 5;
  localparam int          HP    = 6;
  localparam logic [4:0]  CPOL_V = 5'b01100;
  localparam logic [4:0]  CPHA_V = 5'b01010;
  localparam logic [4:0]  MSB_V  = 5'b01111;

  logic       clk = 1'b0;
  logic       rst;
  logic       mosi;
  logic [4:0] cs_v, sclk_v, miso_v, oe_v, tx_load_v, tx_ready_v, rx_valid_v, urun_v, ferr_v;
  logic [7:0] tx_data_v [NDUT];
  logic [7:0] rx_data_v [NDUT];

  int n_rxv  [NDUT] = '{0, 0, 0, 0, 0};
  int n_urun [NDUT] = '{0, 0, 0, 0, 0};
  int n_ferr [NDUT] = '{0, 0, 0, 0, 0};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    spi_slave_frame_if #(.DATA_W(8)) u_if ();
    assign u_if.tx_data   = tx_data_v[g];
    assign u_if.tx_load   = tx_load_v[g];
    assign tx_ready_v[g]  = u_if.tx_ready;
    assign rx_data_v[g]   = u_if.rx_data;
    assign rx_valid_v[g]  = u_if.rx_valid;
    assign urun_v[g]      = u_if.tx_underrun;
    assign ferr_v[g]      = u_if.frame_err;

    spi_slave_frame #(
      .DATA_W      (8),
      .CPOL        (CPOL_V[g]),
      .CPHA        (CPHA_V[g]),
      .MSB_FIRST   (MSB_V[g]),
      .SYNC_STAGES (2)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .cs_n    (cs_v[g]),
      .sclk    (sclk_v[g]),
      .mosi    (mosi),
      .miso    (miso_v[g]),
      .miso_oe (oe_v[g]),
      .bus     (u_if.slave)
    );
  end

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rx_valid_v[k] === 1'b1) n_rxv[k]++;
      if (urun_v[k] === 1'b1)     n_urun[k]++;
      if (ferr_v[k] === 1'b1)     n_ferr[k]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic load_tx(input int k, input logic [7:0] val);
    tx_data_v[k] = val;
    tx_load_v[k] = 1'b1;
    tick(1);
    tx_load_v[k] = 1'b0;
    tick(1);
  endtask

  // Master clocks bits [first, first+count) of the stream; word w occupies data[8w+7:8w]
  task automatic clock_bits(input int k, input logic [23:0] data, input int first, input int count,
                            inout logic [23:0] cap);
    int j;
    for (int i = first; i < first + count; i++) begin
      j = (i / 8) * 8 + (MSB_V[k] ? 7 - (i % 8) : i % 8);
      if (!CPHA_V[k]) begin
        mosi = data[j];
        tick(HP);
        cap[j] = miso_v[k];
        sclk_v[k] = ~CPOL_V[k];
        tick(HP);
        sclk_v[k] = CPOL_V[k];
      end else begin
        sclk_v[k] = ~CPOL_V[k];
        mosi = data[j];
        tick(HP);
        cap[j] = miso_v[k];
        sclk_v[k] = CPOL_V[k];
        tick(HP);
      end
    end
  endtask

  task automatic run_frame(input int k, input logic [23:0] data, input int nbits, output logic [23:0] cap);
    logic [23:0] c;
    c = '0;
    cs_v[k] = 1'b0;
    tick(HP);
    clock_bits(k, data, 0, nbits, c);
    tick(HP);
    cs_v[k] = 1'b1;
    tick(HP + 2);
    cap = c;
  endtask

  typedef struct {
    int          dut;
    logic [23:0] data;
    int          nbits;
    bit          preload;
    logic [7:0]  tx;
    logic [7:0]  exp_rx;
    int          exp_rxv;
    logic [23:0] exp_miso;
    int          exp_urun;
    int          exp_ferr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] cap;
    int          b_rxv, b_urun, b_ferr;

    vecs[0] = '{0, 24'h0000A5, 8,  1'b1, 8'h3C, 8'hA5, 1, 24'h00003C, 0, 0};
    vecs[1] = '{1, 24'h00005A, 8,  1'b1, 8'h5A, 8'h5A, 1, 24'h00005A, 0, 0};
    vecs[2] = '{2, 24'h00005A, 8,  1'b1, 8'h5A, 8'h5A, 1, 24'h00005A, 0, 0};
    vecs[3] = '{3, 24'h00005A, 8,  1'b1, 8'h5A, 8'h5A, 1, 24'h00005A, 0, 0};
    vecs[4] = '{4, 24'h000001, 8,  1'b1, 8'h01, 8'h01, 1, 24'h000001, 0, 0};
    vecs[5] = '{0, 24'h332211, 24, 1'b1, 8'h44, 8'h33, 3, 24'h000044, 2, 0};
    vecs[6] = '{0, 24'h0000FF, 5,  1'b0, 8'h00, 8'h33, 0, 24'h000000, 1, 1};
    vecs[7] = '{0, 24'h000081, 8,  1'b0, 8'h00, 8'h81, 1, 24'h000000, 1, 0};

    rst       = 1'b1;
    mosi      = 1'b0;
    cs_v      = '1;
    sclk_v    = CPOL_V;
    tx_load_v = '0;
    for (int k = 0; k < NDUT; k++) tx_data_v[k] = '0;
    tick(3);
    rst = 1'b0;
    tick(1);

    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset d%0d miso", k),     32'(miso_v[k]),     32'h0);
      check($sformatf("reset d%0d miso_oe", k),  32'(oe_v[k]),       32'h0);
      check($sformatf("reset d%0d tx_ready", k), 32'(tx_ready_v[k]), 32'h1);
      check($sformatf("reset d%0d rx_data", k),  32'(rx_data_v[k]),  32'h0);
      check($sformatf("reset d%0d pulses", k),
            32'({rx_valid_v[k], urun_v[k], ferr_v[k]}), 32'h0);
    end
    tick(HP);

    for (int i = 0; i < 8; i++) begin
      int k;
      k = vecs[i].dut;
      if (vecs[i].preload) load_tx(k, vecs[i].tx);
      b_rxv  = n_rxv[k];
      b_urun = n_urun[k];
      b_ferr = n_ferr[k];
      run_frame(k, vecs[i].data, vecs[i].nbits, cap);
      check($sformatf("v%0d rx_data", i),     32'(rx_data_v[k]),      32'(vecs[i].exp_rx));
      check($sformatf("v%0d rx_valid cnt", i), 32'(n_rxv[k] - b_rxv),  32'(vecs[i].exp_rxv));
      check($sformatf("v%0d miso stream", i), 32'(cap),               32'(vecs[i].exp_miso));
      check($sformatf("v%0d underrun cnt", i), 32'(n_urun[k] - b_urun), 32'(vecs[i].exp_urun));
      check($sformatf("v%0d frame_err cnt", i), 32'(n_ferr[k] - b_ferr), 32'(vecs[i].exp_ferr));
    end

    // tx_load while the holding register is full must be ignored
    load_tx(0, 8'h96);
    check("hold full tx_ready", 32'(tx_ready_v[0]), 32'h0);
    load_tx(0, 8'h69);
    check("ignored load tx_ready", 32'(tx_ready_v[0]), 32'h0);
    b_urun = n_urun[0];
    cap = '0;
    cs_v[0] = 1'b0;
    tick(HP);
    check("frame miso_oe", 32'(oe_v[0]), 32'h1);
    clock_bits(0, 24'h000000, 0, 8, cap);
    tick(HP);
    cs_v[0] = 1'b1;
    tick(HP + 2);
    check("ignored load miso", 32'(cap), 32'h96);
    check("ignored load rx", 32'(rx_data_v[0]), 32'h00);
    check("ignored load underrun", 32'(n_urun[0] - b_urun), 32'h0);
    check("post frame miso_oe", 32'(oe_v[0]), 32'h0);
    check("post frame tx_ready", 32'(tx_ready_v[0]), 32'h1);

    // Reset after 4 bits with cs_n held low: remainder of the frame is ignored
    load_tx(0, 8'h55);
    cap = '0;
    cs_v[0] = 1'b0;
    tick(HP);
    clock_bits(0, 24'h0000F0, 0, 4, cap);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst rx_data", 32'(rx_data_v[0]), 32'h0);
    check("midrst miso_oe", 32'(oe_v[0]), 32'h0);
    check("midrst miso", 32'(miso_v[0]), 32'h0);
    check("midrst tx_ready", 32'(tx_ready_v[0]), 32'h1);
    b_rxv  = n_rxv[0];
    b_urun = n_urun[0];
    b_ferr = n_ferr[0];
    clock_bits(0, 24'h0000F0, 4, 4, cap);
    check("midrst oe during rest", 32'(oe_v[0]), 32'h0);
    tick(HP);
    cs_v[0] = 1'b1;
    tick(HP + 2);
    check("midrst pulses", 32'((n_rxv[0] - b_rxv) + (n_urun[0] - b_urun) + (n_ferr[0] - b_ferr)), 32'h0);
    check("midrst rx_data kept", 32'(rx_data_v[0]), 32'h0);
    b_rxv = n_rxv[0];
    run_frame(0, 24'h0000C3, 8, cap);
    check("post rst rx_data", 32'(rx_data_v[0]), 32'hC3);
    check("post rst rx_valid cnt", 32'(n_rxv[0] - b_rxv), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_frame.md
# spi_slave_frame

Parametrised SPI slave for the FPGA/ESP8266 control path, replacing the fixed 3-bit receive-only slave. Oversamples `cs_n`/`sclk`/`mosi` on the system clock, supports all four SPI modes, configurable word width and bit order, multi-word frames, and full-duplex MISO readback. Received words feed the PWM control registers; transmit words return status to the master.

## Interface
- `DATA_W`, 8, word width in bits (≥2)
- `CPOL`, 0, SCLK idle level
- `CPHA`, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- `MSB_FIRST`, 1, 1 = MSB shifted first on both MOSI and MISO
- `SYNC_STAGES`, 2, synchroniser depth on `cs_n`/`sclk`/`mosi` (≥2)

- `clk` in 1 system/sampling clock
- `rst` in 1 synchronous reset, active-high
- `cs_n` in 1 chip select from master, active-low, asynchronous
- `sclk` in 1 SPI clock, asynchronous
- `mosi` in 1 master data, asynchronous
- `miso` out 1 slave data
- `miso_oe` out 1 high while frame active (drive enable for tri-state pad)
- `tx_data` in DATA_W next word to transmit
- `tx_load` in 1 write `tx_data` into transmit holding register
- `tx_ready` out 1 holding register empty
- `rx_data` out DATA_W last complete received word
- `rx_valid` out 1 one-cycle pulse, `rx_data` updated
- `tx_underrun` out 1 one-cycle pulse, word started with holding register empty
- `frame_err` out 1 one-cycle pulse, `cs_n` rose mid-word

## Operation
- Inputs pass through SYNC_STAGES flops; edges detected on synchronised `sclk` against its previous value.
- Leading edge = `sclk` leaving CPOL level; trailing = returning to it. Sample edge = leading if CPHA=0, else trailing; shift edge = the other.
- States: `IDLE`, `ARMED`, `ACTIVE`.
  - `IDLE`: entered on reset; waits for synced `cs_n` high, then `ARMED`. Prevents joining a frame mid-stream after reset.
  - `ARMED`: synced `cs_n` low -> `ACTIVE`; bit counter cleared; word load performed.
  - `ACTIVE`: sample edge shifts `mosi` into RX shift register, bit counter +1. At count DATA_W-1 sample: `rx_data` <= assembled word including current bit, `rx_valid` pulses, counter wraps to 0, next word load scheduled. Synced `cs_n` high -> `ARMED`; if counter ≠ 0, `frame_err` pulses, partial word discarded, `rx_data` unchanged.
- Word load: TX shift register <= holding register, holding emptied (`tx_ready`=1); if empty, loads 0 and pulses `tx_underrun`.
- CPHA=0: first bit on `miso` at word load; next bit on each shift edge. CPHA=1: bit presented on each shift edge (leading), first bit included. Word-boundary load for CPHA=0 occurs on the last trailing edge.
- `tx_load` accepted only while `tx_ready`=1; ignored otherwise. Load and word-load consume in same cycle with holding empty: underrun pulses, loaded value held for next word.
- Sclk edges while not `ACTIVE` ignored. `miso` = 0 when `miso_oe` = 0.

## Timing
- Reset values: `miso` 0, `miso_oe` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `tx_underrun` 0, `frame_err` 0, state `IDLE`, counters 0.
- `rx_valid` asserts SYNC_STAGES+1 `clk` cycles after the pin-level last sample edge.
- `miso` changes SYNC_STAGES+1 cycles after pin-level shift edge / `cs_n` fall.
- Required: `sclk` high and low each ≥ SYNC_STAGES+2 `clk` periods; `cs_n` setup to first edge ≥ same.
- Reset mid-frame: all outputs to reset values next cycle; no pulses; rest of that frame ignored.

## Structure
- Package `spi_pkg`: state enum (`IDLE`/`ARMED`/`ACTIVE`), edge-select helper deriving sample/shift edge from CPOL/CPHA.
- Sub-module `spi_input_sync`: SYNC_STAGES synchroniser for the three pins plus `sclk` rise/fall detection.

## Test plan
- Mode 0, DATA_W=8, MSB_FIRST: master sends 0xA5 -> `rx_data`=0xA5, one `rx_valid`; with `tx_data`=0x3C preloaded, master reads 0x3C.
- Modes 1/2/3 each, 0x5A both ways -> identical received/transmitted values; LSB_FIRST variant exchanges 0x01 correctly.
- Three-word frame 0x11,0x22,0x33 with only 0x44 loaded -> three `rx_valid`; MISO 0x44,0x00,0x00; two `tx_underrun` pulses.
- `cs_n` raised after 5 bits -> `frame_err` pulse, no `rx_valid`, `rx_data` keeps prior value; next frame 0x81 received correctly.
- `rst` asserted after 4 bits, released with `cs_n` still low -> rest of frame ignored; after `cs_n` high/low, 0xC3 received.
- `tx_load` while `tx_ready`=0 -> ignored, original holding value transmitted.
